// File: rtl/panel_input_conditioner_if.sv
// Front-panel bundle between the raw panel inputs, the controller's lock
// signal and the conditioned outputs the controller FSM consumes.
interface panel_input_conditioner_if;
  logic       start_raw;
  logic       door_raw;
  logic       soap_raw;
  logic [2:0] prog_raw;
  logic       lock_door;
  logic       start;
  logic       doorclosed;
  logic       soap;
  logic [2:0] program_selection;
  logic       prog_valid;
  logic       start_rejected;

  modport master (
    output start_raw, door_raw, soap_raw, prog_raw, lock_door,
    input  start, doorclosed, soap, program_selection, prog_valid, start_rejected
  );

  modport slave (
    input  start_raw, door_raw, soap_raw, prog_raw, lock_door,
    output start, doorclosed, soap, program_selection, prog_valid, start_rejected
  );
endinterface

// File: rtl/panel_input_conditioner.sv
// Synchronises and debounces the washing-machine panel inputs, latches the
// program unless the door is locked, and qualifies start presses into pulses.
module panel_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  panel_input_conditioner_if.slave    pif
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Single-bit channels: bit 0 start, bit 1 door, bit 2 soap
  logic [2:0]      w_raw;
  logic [2:0]      r_s1, r_s2, r_deb, w_deb_nxt;
  logic [2:0][7:0] r_cnt, w_cnt_nxt;

  logic [2:0] r_p1, r_p2, r_pprev, r_pdeb, w_pdeb_nxt;
  logic [7:0] r_pcnt, w_pcnt_nxt;

  logic [1:0] r_prime;
  logic       r_armed, r_start, r_rej;
  logic [2:0] r_sel;
  logic       w_press, w_ok, w_prog_valid;

  assign w_raw = {pif.soap_raw, pif.door_raw, pif.start_raw};

  always_comb begin
    w_deb_nxt = r_deb;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < 3; i++) begin
      if (r_s2[i] == r_deb[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == LAST) begin
        w_deb_nxt[i] = r_s2[i];
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 8'd1;
      end
    end
  end

  // The program bus must also hold still between samples, so a switch
  // rolling through intermediate codes never gets accepted.
  always_comb begin
    w_pdeb_nxt = r_pdeb;
    w_pcnt_nxt = r_pcnt + 8'd1;
    if (r_p2 == r_pdeb || r_p2 != r_pprev) begin
      w_pcnt_nxt = '0;
    end else if (r_pcnt == LAST) begin
      w_pdeb_nxt = r_p2;
      w_pcnt_nxt = '0;
    end
  end

  assign w_prog_valid = (r_sel <= 3'd4);
  assign w_press      = r_armed & ~r_deb[0] & w_deb_nxt[0];
  assign w_ok         = ~pif.lock_door & r_deb[1] & w_prog_valid;

  // Arming waits until the synchroniser holds real samples and both the
  // synced and debounced start are low, so a button held through reset
  // has to be released before it can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_pprev <= '0;
      r_pdeb  <= '0;
      r_pcnt  <= '0;
      r_prime <= '0;
      r_armed <= 1'b0;
      r_start <= 1'b0;
      r_rej   <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb   <= w_deb_nxt;
      r_cnt   <= w_cnt_nxt;
      r_p1    <= pif.prog_raw;
      r_p2    <= r_p1;
      r_pprev <= r_p2;
      r_pdeb  <= w_pdeb_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_prime <= {r_prime[0], 1'b1};
      r_armed <= r_armed | (r_prime[1] & ~r_s2[0] & ~r_deb[0]);
      r_start <= w_press & w_ok;
      r_rej   <= w_press & ~w_ok;
      if (!pif.lock_door) r_sel <= r_pdeb;
    end
  end

  assign pif.start             = r_start;
  assign pif.start_rejected    = r_rej;
  assign pif.doorclosed        = r_deb[1];
  assign pif.soap              = r_deb[2];
  assign pif.program_selection = r_sel;
  assign pif.prog_valid        = w_prog_valid;
endmodule
